// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with programmable modulus, variable step and wrap/overflow flags.
// Optional feature macro: UPDOWN_SAT_EN compiles in the saturate path selected by sat_mode.
module updown_counter_param #(
    parameter int WIDTH     = 8,
    parameter int MAX_VAL   = 2**WIDTH - 1,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             increment,
    input  logic             decrement,
    input  logic [WIDTH-1:0] step,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap_pulse,
    output logic             ovf_sticky,
    output logic             udf_sticky
);

    localparam logic [WIDTH:0]   MAX_EXT   = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   MOD_EXT   = MAX_EXT + {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAX_CNT   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_CNT = WIDTH'(RESET_VAL);

    logic             sat;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   load_ext;
    logic [WIDTH:0]   step_eff;
    logic [WIDTH:0]   load_eff;
    logic [WIDTH:0]   cnt_ext;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   up_wrap;
    logic [WIDTH:0]   dn_diff;
    logic [WIDTH:0]   dn_wrap;
    logic [WIDTH-1:0] next_count;
    logic             next_wrap;
    logic             next_ovf;
    logic             next_udf;

`ifdef UPDOWN_SAT_EN
    assign sat = sat_mode;
`else
    logic unused_sat_mode;
    assign unused_sat_mode = sat_mode;
    assign sat = 1'b0;
`endif

    // Widened operands and candidate results; WIDTH+1 bits keeps every intermediate exact.
    always_comb begin
        step_ext = {1'b0, step};
        load_ext = {1'b0, load_val};
        cnt_ext  = {1'b0, count};
        step_eff = (step_ext > MAX_EXT) ? MAX_EXT : step_ext;
        load_eff = (load_ext > MAX_EXT) ? MAX_EXT : load_ext;
        up_sum   = cnt_ext + step_eff;
        up_wrap  = up_sum - MOD_EXT;
        dn_diff  = cnt_ext - step_eff;
        dn_wrap  = cnt_ext + MOD_EXT - step_eff;
    end

    // Next-state selection: clear > load > count > hold.
    always_comb begin
        next_count = count;
        next_wrap  = 1'b0;
        next_ovf   = ovf_sticky;
        next_udf   = udf_sticky;
        if (clear) begin
            next_count = RESET_CNT;
            next_ovf   = 1'b0;
            next_udf   = 1'b0;
        end else if (load) begin
            next_count = load_eff[WIDTH-1:0];
        end else if (increment ^ decrement) begin
            if (increment) begin
                if (up_sum > MAX_EXT) begin
                    next_ovf = 1'b1;
                    if (sat) begin
                        next_count = MAX_CNT;
                    end else begin
                        next_count = up_wrap[WIDTH-1:0];
                        next_wrap  = 1'b1;
                    end
                end else begin
                    next_count = up_sum[WIDTH-1:0];
                end
            end else begin
                if (step_eff > cnt_ext) begin
                    next_udf = 1'b1;
                    if (sat) begin
                        next_count = {WIDTH{1'b0}};
                    end else begin
                        next_count = dn_wrap[WIDTH-1:0];
                        next_wrap  = 1'b1;
                    end
                end else begin
                    next_count = dn_diff[WIDTH-1:0];
                end
            end
        end else begin
            next_count = count;
        end
    end

    // State register; reset forces the idle state immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= RESET_CNT;
            wrap_pulse <= 1'b0;
            ovf_sticky <= 1'b0;
            udf_sticky <= 1'b0;
        end else begin
            count      <= next_count;
            wrap_pulse <= next_wrap;
            ovf_sticky <= next_ovf;
            udf_sticky <= next_udf;
        end
    end

    assign at_max = (count == MAX_CNT);
    assign at_min = (count == {WIDTH{1'b0}});

endmodule

// File: tb/tb_updown_counter_param.sv
// Self-checking bench for updown_counter_param (WIDTH=4, MAX_VAL=9, RESET_VAL=0).
// Directed test-plan steps followed by randomized traffic against an integer reference model.
module tb_updown_counter_param;

    localparam int W    = 4;
    localparam int MAXV = 9;
    localparam int MODV = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         clear;
    logic         load;
    logic [W-1:0] load_val;
    logic         increment;
    logic         decrement;
    logic [W-1:0] step;
    logic         sat_mode;
    logic [W-1:0] count;
    logic         at_max;
    logic         at_min;
    logic         wrap_pulse;
    logic         ovf_sticky;
    logic         udf_sticky;

    int  checks   = 0;
    int  failures = 0;
    int  m_count  = 0;
    bit  m_wrap   = 1'b0;
    bit  m_ovf    = 1'b0;
    bit  m_udf    = 1'b0;
    bit  sat_en;

    updown_counter_param #(.WIDTH(W), .MAX_VAL(MAXV), .RESET_VAL(0)) dut (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .increment(increment), .decrement(decrement), .step(step), .sat_mode(sat_mode),
        .count(count), .at_max(at_max), .at_min(at_min), .wrap_pulse(wrap_pulse),
        .ovf_sticky(ovf_sticky), .udf_sticky(udf_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"}, int'(count), m_count);
        check({tag, ".wrap"},  int'(wrap_pulse), int'(m_wrap));
        check({tag, ".ovf"},   int'(ovf_sticky), int'(m_ovf));
        check({tag, ".udf"},   int'(udf_sticky), int'(m_udf));
        check({tag, ".at_max"}, int'(at_max), int'(m_count == MAXV));
        check({tag, ".at_min"}, int'(at_min), int'(m_count == 0));
    endtask

    // Reference model: arithmetic on plain integers, modulus MAXV+1.
    task automatic model_edge();
        int  st;
        int  v;
        bit  sat;
        st  = (int'(step) > MAXV) ? MAXV : int'(step);
        sat = sat_en && sat_mode;
        if (reset) begin
            m_count = 0; m_wrap = 0; m_ovf = 0; m_udf = 0;
        end else if (clear) begin
            m_count = 0; m_wrap = 0; m_ovf = 0; m_udf = 0;
        end else if (load) begin
            m_count = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
            m_wrap  = 0;
        end else if (increment != decrement) begin
            m_wrap = 0;
            v = increment ? m_count + st : m_count - st;
            if (v > MAXV) begin
                m_ovf = 1;
                if (sat) m_count = MAXV;
                else begin m_count = v - MODV; m_wrap = 1; end
            end else if (v < 0) begin
                m_udf = 1;
                if (sat) m_count = 0;
                else begin m_count = v + MODV; m_wrap = 1; end
            end else begin
                m_count = v;
            end
        end else begin
            m_wrap = 0;
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input bit c, input bit l, input int lv, input bit inc, input bit dec,
                         input int st, input bit sm);
        clear = c; load = l; load_val = W'(lv); increment = inc; decrement = dec;
        step = W'(st); sat_mode = sm;
    endtask

    initial begin
`ifdef UPDOWN_SAT_EN
        sat_en = 1'b1;
`else
        sat_en = 1'b0;
`endif
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        #3;
        check_all("reset_init");
        @(posedge clk); #1;
        reset = 1'b0;

        // Load then asynchronous reset between edges
        drive(0, 1, 5, 0, 0, 0, 0);
        tick("load5");
        check("load5.const", int'(count), 5);
        drive(0, 0, 0, 1, 0, 1, 0);
        #2;
        reset = 1'b1;
        m_count = 0; m_wrap = 0; m_ovf = 0; m_udf = 0;
        #1;
        check_all("async_reset");
        check("async_reset.const", int'(count), 0);
        tick("reset_hold");
        reset = 1'b0;

        // Up wrap from 9
        drive(0, 1, 9, 0, 0, 0, 0);
        tick("load9");
        drive(0, 0, 0, 1, 0, 1, 0);
        tick("up_wrap");
        check("up_wrap.count", int'(count), 0);
        check("up_wrap.pulse", int'(wrap_pulse), 1);
        drive(0, 0, 0, 0, 0, 1, 0);
        tick("wrap_one_cycle");
        check("wrap_one_cycle.pulse", int'(wrap_pulse), 0);
        check("ovf_stays", int'(ovf_sticky), 1);

        // Down wrap from 2 by 5, then clear
        drive(0, 1, 2, 0, 0, 0, 0);
        tick("load2");
        drive(0, 0, 0, 0, 1, 5, 0);
        tick("dn_wrap");
        check("dn_wrap.count", int'(count), 7);
        check("dn_wrap.udf", int'(udf_sticky), 1);
        drive(1, 0, 0, 0, 0, 0, 0);
        tick("clear");
        check("clear.count", int'(count), 0);
        check("clear.ovf", int'(ovf_sticky), 0);

        // Tie on direction and zero step both hold
        drive(0, 1, 4, 0, 0, 0, 0);
        tick("load4");
        drive(0, 0, 0, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) tick("tie_hold");
        check("tie_hold.const", int'(count), 4);
        drive(0, 0, 0, 1, 0, 0, 0);
        tick("step0_hold");
        check("step0_hold.const", int'(count), 4);

        // Load clamps and beats count; clear beats load
        drive(0, 1, 12, 1, 0, 1, 0);
        tick("load_clamp");
        check("load_clamp.count", int'(count), 9);
        check("load_clamp.at_max", int'(at_max), 1);
        drive(1, 1, 3, 0, 0, 0, 0);
        tick("clear_wins");
        check("clear_wins.count", int'(count), 0);

        // Oversized step is treated as MAX_VAL: 3 + 9 wraps to 2
        drive(0, 1, 3, 0, 0, 0, 0);
        tick("load3");
        drive(0, 0, 0, 1, 0, 15, 0);
        tick("big_step");
        check("big_step.count", int'(count), 2);

`ifdef UPDOWN_SAT_EN
        drive(1, 0, 0, 0, 0, 0, 1);
        tick("sat_clear");
        drive(0, 1, 8, 0, 0, 0, 1);
        tick("load8");
        drive(0, 0, 0, 1, 0, 3, 1);
        tick("sat_up");
        check("sat_up.count", int'(count), 9);
        check("sat_up.ovf", int'(ovf_sticky), 1);
        check("sat_up.pulse", int'(wrap_pulse), 0);
        drive(0, 1, 1, 0, 0, 0, 1);
        tick("load1");
        drive(0, 0, 0, 0, 1, 4, 1);
        tick("sat_dn");
        check("sat_dn.count", int'(count), 0);
        check("sat_dn.udf", int'(udf_sticky), 1);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 9) == 0),
                  int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 15)), 1'($urandom));
            if ($urandom_range(0, 99) == 0) begin
                #2;
                reset = 1'b1;
                m_count = 0; m_wrap = 0; m_ovf = 0; m_udf = 0;
                #1;
                check_all("rnd_reset");
                tick("rnd_reset_hold");
                reset = 1'b0;
            end else begin
                tick("rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
